// File: rtl/frame_update_sched_if.sv
// Handshake and count bundle between the sync-to-count stage, the vblank scheduler
// and the game-logic update clients.
interface frame_update_sched_if #(
   parameter int unsigned NUM_CLIENTS = 4
);
   logic [9:0]             i_Col_Count;
   logic [9:0]             i_Row_Count;
   logic                   i_Enable;
   logic [NUM_CLIENTS-1:0] i_Done;
   logic [NUM_CLIENTS-1:0] o_Req;
   logic                   o_Frame_Tick;
   logic                   o_Busy;
   logic [7:0]             o_Frame_Num;
   logic [NUM_CLIENTS-1:0] o_Timeout_Err;
   logic                   o_Overrun;

   modport master (
      input  i_Col_Count, i_Row_Count, i_Enable, i_Done,
      output o_Req, o_Frame_Tick, o_Busy, o_Frame_Num, o_Timeout_Err, o_Overrun
   );

   modport slave (
      output i_Col_Count, i_Row_Count, i_Enable, i_Done,
      input  o_Req, o_Frame_Tick, o_Busy, o_Frame_Num, o_Timeout_Err, o_Overrun
   );
endinterface

// File: rtl/frame_update_sched.sv
// Vertical-blank scheduler: grants one update slot at a time to each client during
// vblank, with a per-grant timeout and an abort at the frame deadline.
module frame_update_sched #(
   parameter int unsigned ACTIVE_ROWS    = 480,
   parameter int unsigned TOTAL_COLS     = 800,
   parameter int unsigned TOTAL_ROWS     = 525,
   parameter int unsigned NUM_CLIENTS    = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input logic                  i_Clk,
   input logic                  i_Rst_L,
   frame_update_sched_if.master bus
);

   localparam int unsigned IdxW = $clog2(NUM_CLIENTS);
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e                 state_q, state_d;
   logic [IdxW-1:0]        idx_q, idx_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic                   tick_q, tick_d;
   logic [7:0]             frame_num_q, frame_num_d;
   logic [NUM_CLIENTS-1:0] terr_q, terr_d;
   logic                   overrun_q, overrun_d;

   logic trigger, deadline, done_cur, timed_out, last_client;

   assign trigger     = (bus.i_Row_Count == 10'(ACTIVE_ROWS)) && (bus.i_Col_Count == 10'd0);
   assign deadline    = (bus.i_Row_Count == 10'(TOTAL_ROWS - 1)) &&
                        (bus.i_Col_Count == 10'(TOTAL_COLS - 1));
   // Only the currently granted client's done bit is ever looked at.
   assign done_cur    = bus.i_Done[idx_q];
   assign timed_out   = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
   assign last_client = (idx_q == IdxW'(NUM_CLIENTS - 1));

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      tick_d      = 1'b0;
      frame_num_d = frame_num_q;
      terr_d      = terr_q;
      overrun_d   = overrun_q;
      unique case (state_q)
         StIdle: begin
            if (trigger && bus.i_Enable) begin
               state_d     = StGrant;
               idx_d       = '0;
               cnt_d       = '0;
               tick_d      = 1'b1;
               frame_num_d = frame_num_q + 8'd1;
            end
         end
         StGrant: begin
            if (deadline) begin
               state_d   = StIdle;
               idx_d     = '0;
               cnt_d     = '0;
               overrun_d = 1'b1;
            end else if (done_cur || timed_out) begin
               // A done on the final timeout cycle wins, so no error is flagged.
               if (!done_cur) begin
                  terr_d[idx_q] = 1'b1;
               end
               cnt_d = '0;
               if (last_client) begin
                  state_d = StIdle;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + IdxW'(1);
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_q     <= StIdle;
         idx_q       <= '0;
         cnt_q       <= '0;
         tick_q      <= 1'b0;
         frame_num_q <= '0;
         terr_q      <= '0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         tick_q      <= tick_d;
         frame_num_q <= frame_num_d;
         terr_q      <= terr_d;
         overrun_q   <= overrun_d;
      end
   end

   // Request and busy decode from state so reset clears them without a clock.
   assign bus.o_Req         = (state_q == StGrant) ? (NUM_CLIENTS'(1) << idx_q) : '0;
   assign bus.o_Busy        = (state_q == StGrant);
   assign bus.o_Frame_Tick  = tick_q;
   assign bus.o_Frame_Num   = frame_num_q;
   assign bus.o_Timeout_Err = terr_q;
   assign bus.o_Overrun     = overrun_q;

endmodule

// File: tb/tb_frame_update_sched.sv
// Directed bench for frame_update_sched with shrunken frame geometry and timeout.
module tb_frame_update_sched;

   localparam int unsigned ACTIVE_ROWS    = 4;
   localparam int unsigned TOTAL_COLS     = 8;
   localparam int unsigned TOTAL_ROWS     = 6;
   localparam int unsigned NUM_CLIENTS    = 4;
   localparam int unsigned TIMEOUT_CYCLES = 8;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;
   int   busy_cnt;
   int   held;

   frame_update_sched_if #(.NUM_CLIENTS(NUM_CLIENTS)) bus ();

   frame_update_sched #(
      .ACTIVE_ROWS    (ACTIVE_ROWS),
      .TOTAL_COLS     (TOTAL_COLS),
      .TOTAL_ROWS     (TOTAL_ROWS),
      .NUM_CLIENTS    (NUM_CLIENTS),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .i_Clk   (clk),
      .i_Rst_L (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present the trigger position for one cycle, then park the counts mid-frame.
   task automatic trigger_frame();
      bus.i_Row_Count = 10'(ACTIVE_ROWS);
      bus.i_Col_Count = 10'd0;
      step();
      bus.i_Row_Count = 10'd1;
      bus.i_Col_Count = 10'd3;
   endtask

   initial begin
      n_checks        = 0;
      n_errors        = 0;
      rst_n           = 1'b0;
      bus.i_Row_Count = 10'd1;
      bus.i_Col_Count = 10'd3;
      bus.i_Enable    = 1'b1;
      bus.i_Done      = '0;
      #2;
      check("rst_req", 32'(bus.o_Req), 32'h0);
      check("rst_busy", 32'(bus.o_Busy), 32'h0);
      check("rst_tick", 32'(bus.o_Frame_Tick), 32'h0);
      check("rst_fnum", 32'(bus.o_Frame_Num), 32'h0);
      check("rst_terr", 32'(bus.o_Timeout_Err), 32'h0);
      check("rst_ovr", 32'(bus.o_Overrun), 32'h0);
      step();
      rst_n = 1'b1;
      step();

      // Nominal: each grant held three cycles.
      trigger_frame();
      check("nom_tick", 32'(bus.o_Frame_Tick), 32'h1);
      check("nom_fnum", 32'(bus.o_Frame_Num), 32'h1);
      busy_cnt = 0;
      for (int k = 0; k < 4; k++) begin
         check("nom_req", 32'(bus.o_Req), 32'h1 << k);
         busy_cnt += int'(bus.o_Busy);
         step();
         if (k == 0) check("nom_tick_once", 32'(bus.o_Frame_Tick), 32'h0);
         busy_cnt += int'(bus.o_Busy);
         step();
         busy_cnt += int'(bus.o_Busy);
         bus.i_Done = 4'(1 << k);
         step();
         bus.i_Done = '0;
      end
      check("nom_req_end", 32'(bus.o_Req), 32'h0);
      check("nom_busy_end", 32'(bus.o_Busy), 32'h0);
      check("nom_busy_cycles", 32'(busy_cnt), 32'd12);
      check("nom_terr", 32'(bus.o_Timeout_Err), 32'h0);

      // Timeout on client 1.
      trigger_frame();
      check("to_fnum", 32'(bus.o_Frame_Num), 32'h2);
      bus.i_Done = 4'b0001;
      step();
      bus.i_Done = '0;
      held = 0;
      while (bus.o_Req == 4'b0010 && held < 20) begin
         held++;
         step();
      end
      check("to_held", 32'(held), 32'd8);
      check("to_next_req", 32'(bus.o_Req), 32'h4);
      check("to_terr", 32'(bus.o_Timeout_Err), 32'h2);
      bus.i_Done = 4'b1111;
      step();
      step();
      bus.i_Done = '0;
      check("to_done_busy", 32'(bus.o_Busy), 32'h0);

      // Deadline overrun while client 0 holds its grant.
      trigger_frame();
      check("dl_req0", 32'(bus.o_Req), 32'h1);
      step();
      step();
      bus.i_Row_Count = 10'(TOTAL_ROWS - 1);
      bus.i_Col_Count = 10'(TOTAL_COLS - 1);
      step();
      bus.i_Row_Count = 10'd1;
      bus.i_Col_Count = 10'd3;
      check("dl_req", 32'(bus.o_Req), 32'h0);
      check("dl_busy", 32'(bus.o_Busy), 32'h0);
      check("dl_ovr", 32'(bus.o_Overrun), 32'h1);
      trigger_frame();
      check("dl_restart_req", 32'(bus.o_Req), 32'h1);
      check("dl_ovr_sticky", 32'(bus.o_Overrun), 32'h1);
      check("dl_restart_fnum", 32'(bus.o_Frame_Num), 32'h4);
      bus.i_Done = 4'b1111;
      repeat (4) step();
      bus.i_Done = '0;
      check("dl_done_busy", 32'(bus.o_Busy), 32'h0);

      // Enable gating and stray done filtering.
      bus.i_Enable = 1'b0;
      trigger_frame();
      check("en_tick", 32'(bus.o_Frame_Tick), 32'h0);
      check("en_busy", 32'(bus.o_Busy), 32'h0);
      check("en_fnum", 32'(bus.o_Frame_Num), 32'h4);
      bus.i_Enable = 1'b1;
      trigger_frame();
      check("en2_fnum", 32'(bus.o_Frame_Num), 32'h5);
      bus.i_Done = 4'b1110;
      step();
      step();
      check("stray_req", 32'(bus.o_Req), 32'h1);
      bus.i_Enable = 1'b0;
      bus.i_Done   = 4'b0001;
      step();
      check("en_fall_req", 32'(bus.o_Req), 32'h2);
      bus.i_Done = 4'b1111;
      repeat (3) step();
      bus.i_Done   = '0;
      bus.i_Enable = 1'b1;
      check("en_fall_busy", 32'(bus.o_Busy), 32'h0);

      // Done on the last timeout cycle, then async reset mid-grant.
      trigger_frame();
      repeat (7) step();
      bus.i_Done = 4'b0001;
      step();
      bus.i_Done = '0;
      check("col_req", 32'(bus.o_Req), 32'h2);
      check("col_terr", 32'(bus.o_Timeout_Err), 32'h2);
      step();
      check("col_busy", 32'(bus.o_Busy), 32'h1);
      rst_n = 1'b0;
      #2;
      check("arst_req", 32'(bus.o_Req), 32'h0);
      check("arst_busy", 32'(bus.o_Busy), 32'h0);
      check("arst_fnum", 32'(bus.o_Frame_Num), 32'h0);
      check("arst_terr", 32'(bus.o_Timeout_Err), 32'h0);
      check("arst_ovr", 32'(bus.o_Overrun), 32'h0);
      step();
      rst_n = 1'b1;
      step();

      // Frame number wrap.
      for (int i = 1; i <= 256; i++) begin
         trigger_frame();
         if (i == 255) check("wrap_255", 32'(bus.o_Frame_Num), 32'd255);
         bus.i_Done = 4'b1111;
         repeat (4) step();
         bus.i_Done = '0;
      end
      check("wrap_0", 32'(bus.o_Frame_Num), 32'd0);
      check("wrap_busy", 32'(bus.o_Busy), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
